tug_of_war_game: RTL and testbench
==================================

# tug_of_war_game

Parametrised two-player tug-of-war game core for the board LED/HEX front panel. It takes raw push-button inputs for a left and a right player, synchronises and edge-detects them, and moves a one-hot "rope" marker across a configurable LED bar. It keeps per-player scores up to a configurable match length, with an optional LFSR-driven CPU opponent of programmable difficulty. It drives the LED bar, two seven-segment score digits and match-status flags directly.

## Interface
- NUM_LEDS, default 9: LED bar length. Odd, 3..31. Centre index C = (NUM_LEDS-1)/2.
- WIN_SCORE, default 7: points that end the match. Range 1..9.
- HOLD_CYCLES, default 4: cycles the point-display phase lasts. ≥1.
- SW = $clog2(WIN_SCORE+1): score width (derived, localparam).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- btn_left  in  1  raw left-player button, active-high, asynchronous.
- btn_right  in  1  raw right-player button, active-high, asynchronous. Ignored while cpu_en=1.
- cpu_en  in  1  when 1, the CPU plays the right side.
- cpu_thresh  in  10  CPU difficulty: CPU presses when lfsr < cpu_thresh.
- pos_leds  out  NUM_LEDS  rope display; bit NUM_LEDS-1 is the left end.
- score_left, score_right  out  SW  current scores.
- hex_left, hex_right  out  7  active-low seven-segment digit of each score.
- game_over  out  1  match finished.
- winner  out  1  valid when game_over: 1 = left, 0 = right.

## Operation
- Button path, per button: sync1 <= btn; sync2 <= sync1; prev <= sync2. Pulse = sync2 & ~prev. Gives one pulse per press regardless of hold length.
- CPU: 10-bit Fibonacci LFSR, taps bits 9 and 6 (x^10+x^7+1), shift left, feedback into bit 0.
  - Reset seed 10'h3FF. Advances every cycle in every state.
  - cpu_pulse is registered: cpu_pulse <= cpu_en & (lfsr < cpu_thresh).
  - cpu_thresh=0 means the CPU never presses. cpu_thresh=10'h3FF means it presses on all cycles except when lfsr=10'h3FF.
- Right pulse = cpu_en ? cpu_pulse : button pulse.
- Position register pos, 0..NUM_LEDS-1. In PLAY, pos_leds = one-hot(pos).
- FSM states PLAY, HOLD, OVER.
  - PLAY:
    - Left-only pulse: pos+1 if pos<NUM_LEDS-1. At pos=NUM_LEDS-1 the left player scores a point.
    - Right-only pulse: pos-1 if pos>0. At pos=0 the right player scores a point.
    - Both pulses in the same cycle, or neither: no change.
  - On a point: that score increments at the same edge.
    - If the new score == WIN_SCORE: go to OVER, game_over<=1, winner set.
    - Else: go to HOLD with hold_cnt<=0.
  - HOLD: pos_leds all ones; all pulses ignored; hold_cnt increments each cycle. In the cycle with hold_cnt==HOLD_CYCLES-1: pos<=C, go to PLAY.
  - OVER: pos_leds all ones; scores, game_over and winner frozen; all pulses ignored until reset.
- hex encoding (score value -> gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Combinational from score.

## Timing
- Reset values:
  - pos=C, pos_leds=one-hot(C), state PLAY.
  - Scores 0, hex_left=hex_right=7'b1000000.
  - game_over=0, winner=0.
  - lfsr=10'h3FF; sync1/sync2/prev=0, cpu_pulse=0, hold_cnt=0.
- Reset mid-match, in any state including HOLD/OVER: all of the above at the next edge; the scores clear.
- A button held high through reset release yields exactly one pulse after release.
- Button latency: btn sampled high at edge n -> pulse high during cycle n+1..n+2 -> pos_leds updates at edge n+2.
- CPU latency: lfsr value below threshold after edge n -> cpu_pulse at edge n+1 -> pos_leds updates at edge n+2.
- Point edge: score, hex and state change together; pos_leds is all ones from that edge.
- HOLD lasts exactly HOLD_CYCLES cycles; the first PLAY cycle shows one-hot(C).
- Outputs are registered except hex_* and pos_leds, which are combinational from state registers.

## Test plan
Scenarios use NUM_LEDS=9, WIN_SCORE=3, HOLD_CYCLES=4.
- Reset -> pos_leds=9'b000010000, scores 0, both hex=1000000, game_over=0.
- Single btn_left pulse, 1 cycle wide, at edge n -> pos_leds=9'b000100000 exactly at edge n+2. Holding btn_left 20 cycles -> only one move.
- btn_left and btn_right rising on the same edge -> no move. Five right presses from centre -> pos 0, then right point: score_right=1, hex_right=1111001, pos_leds=9'h1FF for 4 cycles, then 9'b000010000.
- Left wins 3 points -> game_over=1, winner=1, hex_left=0110000. Further presses of either button -> no change. reset=0 for one edge -> full reset values.
- cpu_en=1, cpu_thresh=0 with btn_right toggling -> rope never moves right. cpu_thresh=10'h3FF -> right presses appear 2 edges after LFSR comparison; right eventually wins 3-0.
- Reset asserted during HOLD (hold_cnt=2) -> next edge state PLAY, pos=C, scores 0, lfsr=10'h3FF.

Source files
------------

// File: rtl/tug_of_war_game.sv
// Two-player tug-of-war game core.
// Raw buttons are synchronised and edge-detected; each accepted press pulls a
// one-hot rope marker one LED towards the pressing player. Pulling the marker
// off the end of the bar scores a point, followed by a short all-on display
// phase (HOLD) before the rope recentres. The first player to WIN_SCORE points
// ends the match (OVER) until reset. An LFSR-driven CPU can play the right side.
// The FSM state is exported on dbg_state (0 = PLAY, 1 = HOLD, 2 = OVER).
module tug_of_war_game #(
  parameter int NUM_LEDS    = 9,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4,
  localparam int SW         = $clog2(WIN_SCORE + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                cpu_en,
  input  logic [9:0]          cpu_thresh,
  output logic [NUM_LEDS-1:0] pos_leds,
  output logic [SW-1:0]       score_left,
  output logic [SW-1:0]       score_right,
  output logic [6:0]          hex_left,
  output logic [6:0]          hex_right,
  output logic                game_over,
  output logic                winner,
  output logic [1:0]          dbg_state
);

  // Rope position width, centre index and the far-left index.
  localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int C  = (NUM_LEDS - 1) / 2;
  // Hold counter only has to reach HOLD_CYCLES-1.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PW-1:0] POS_C     = PW'(C);
  localparam logic [PW-1:0] POS_MAX   = PW'(NUM_LEDS - 1);
  localparam logic [SW-1:0] SCORE_WIN = SW'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [9:0]    LFSR_SEED = 10'h3FF;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Seven-segment encoding, gfedcba, active-low. Values above 9 blank.
  function automatic logic [6:0] f_hex(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Button synchronisers and edge-detect history.
  logic r_sync1_l, r_sync2_l, r_prev_l;
  logic r_sync1_r, r_sync2_r, r_prev_r;

  // CPU opponent.
  logic [9:0] r_lfsr;
  logic       r_cpu_pulse;
  logic       w_lfsr_fb;

  // Game state.
  state_t        r_state;
  logic [PW-1:0] r_pos;
  logic [SW-1:0] r_score_l;
  logic [SW-1:0] r_score_r;
  logic [HW-1:0] r_hold_cnt;
  logic          r_game_over;
  logic          r_winner;

  // Next-state values.
  state_t        w_state_nxt;
  logic [PW-1:0] w_pos_nxt;
  logic [SW-1:0] w_score_l_nxt;
  logic [SW-1:0] w_score_r_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic          w_game_over_nxt;
  logic          w_winner_nxt;

  // Derived pulses and helpers.
  logic                w_pulse_l;
  logic                w_pulse_btn_r;
  logic                w_pulse_r;
  logic                w_move_left;
  logic                w_move_right;
  logic [SW-1:0]       w_score_l_inc;
  logic [SW-1:0]       w_score_r_inc;
  logic [NUM_LEDS-1:0] w_onehot;

  // Two-flop synchroniser plus one history flop per button.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1_l <= 1'b0;
      r_sync2_l <= 1'b0;
      r_prev_l  <= 1'b0;
      r_sync1_r <= 1'b0;
      r_sync2_r <= 1'b0;
      r_prev_r  <= 1'b0;
    end else begin
      r_sync1_l <= btn_left;
      r_sync2_l <= r_sync1_l;
      r_prev_l  <= r_sync2_l;
      r_sync1_r <= btn_right;
      r_sync2_r <= r_sync1_r;
      r_prev_r  <= r_sync2_r;
    end
  end

  // One pulse per rising edge of the synchronised button, however long held.
  assign w_pulse_l     = r_sync2_l & ~r_prev_l;
  assign w_pulse_btn_r = r_sync2_r & ~r_prev_r;

  // x^10 + x^7 + 1 Fibonacci LFSR, shifting left with feedback into bit 0.
  assign w_lfsr_fb = r_lfsr[9] ^ r_lfsr[6];

  // LFSR free-runs in every state; the CPU press decision is registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr      <= LFSR_SEED;
      r_cpu_pulse <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[8:0], w_lfsr_fb};
      r_cpu_pulse <= cpu_en & (r_lfsr < cpu_thresh);
    end
  end

  // The CPU replaces the right button entirely while enabled.
  assign w_pulse_r    = cpu_en ? r_cpu_pulse : w_pulse_btn_r;
  assign w_move_left  = w_pulse_l & ~w_pulse_r;
  assign w_move_right = w_pulse_r & ~w_pulse_l;

  // Scores never exceed WIN_SCORE, so the increment always fits in SW bits.
  assign w_score_l_inc = r_score_l + SW'(1);
  assign w_score_r_inc = r_score_r + SW'(1);

  // Game state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_PLAY;
      r_pos       <= POS_C;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_hold_cnt  <= '0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_game_over <= w_game_over_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  // Next-state logic: rope moves and scoring in PLAY, timed pause in HOLD,
  // everything frozen in OVER.
  always_comb begin
    w_state_nxt     = r_state;
    w_pos_nxt       = r_pos;
    w_score_l_nxt   = r_score_l;
    w_score_r_nxt   = r_score_r;
    w_hold_nxt      = r_hold_cnt;
    w_game_over_nxt = r_game_over;
    w_winner_nxt    = r_winner;
    case (r_state)
      ST_PLAY: begin
        if (w_move_left) begin
          if (r_pos < POS_MAX) begin
            w_pos_nxt = r_pos + PW'(1);
          end else begin
            // Marker already at the left end: left player scores.
            w_score_l_nxt = w_score_l_inc;
            if (w_score_l_inc == SCORE_WIN) begin
              w_state_nxt     = ST_OVER;
              w_game_over_nxt = 1'b1;
              w_winner_nxt    = 1'b1;
            end else begin
              w_state_nxt = ST_HOLD;
              w_hold_nxt  = '0;
            end
          end
        end else if (w_move_right) begin
          if (r_pos > '0) begin
            w_pos_nxt = r_pos - PW'(1);
          end else begin
            // Marker already at the right end: right player scores.
            w_score_r_nxt = w_score_r_inc;
            if (w_score_r_inc == SCORE_WIN) begin
              w_state_nxt     = ST_OVER;
              w_game_over_nxt = 1'b1;
              w_winner_nxt    = 1'b0;
            end else begin
              w_state_nxt = ST_HOLD;
              w_hold_nxt  = '0;
            end
          end
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_PLAY;
          w_pos_nxt   = POS_C;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end
      ST_OVER: begin
        w_state_nxt = ST_OVER;
      end
      default: begin
        w_state_nxt = ST_PLAY;
        w_pos_nxt   = POS_C;
      end
    endcase
  end

  // Rope display: one-hot marker while playing, whole bar lit otherwise.
  assign w_onehot = {{(NUM_LEDS-1){1'b0}}, 1'b1} << r_pos;

  // Select rope display from the current state.
  always_comb begin
    pos_leds = '1;
    if (r_state == ST_PLAY) begin
      pos_leds = w_onehot;
    end
  end

  assign score_left  = r_score_l;
  assign score_right = r_score_r;
  assign hex_left    = f_hex(4'(r_score_l));
  assign hex_right   = f_hex(4'(r_score_r));
  assign game_over   = r_game_over;
  assign winner      = r_winner;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_tug_of_war_game.sv
// Directed bench for tug_of_war_game with NUM_LEDS=9, WIN_SCORE=3, HOLD_CYCLES=4.
module tb_tug_of_war_game;

  localparam logic [8:0] LED_C   = 9'b000010000;
  localparam logic [8:0] LED_ALL = 9'h1FF;
  localparam logic [6:0] HEX0    = 7'b1000000;
  localparam logic [6:0] HEX1    = 7'b1111001;
  localparam logic [6:0] HEX3    = 7'b0110000;
  localparam logic [1:0] S_PLAY  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_OVER  = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       cpu_en = 1'b0;
  logic [9:0] cpu_thresh = 10'd0;
  logic [8:0] pos_leds;
  logic [1:0] score_left, score_right;
  logic [6:0] hex_left, hex_right;
  logic       game_over, winner;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  tug_of_war_game #(.NUM_LEDS(9), .WIN_SCORE(3), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .cpu_en(cpu_en), .cpu_thresh(cpu_thresh), .pos_leds(pos_leds),
    .score_left(score_left), .score_right(score_right),
    .hex_left(hex_left), .hex_right(hex_right),
    .game_over(game_over), .winner(winner), .dbg_state(dbg_state)
  );

  // Clock and safety watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance n clock edges, landing 1 ns after the last one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  // One-cycle-wide press; returns right after the edge that applies the move.
  task automatic press_left();
    btn_left = 1'b1;
    tick(1);
    btn_left = 1'b0;
    tick(2);
  endtask

  task automatic press_right();
    btn_right = 1'b1;
    tick(1);
    btn_right = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL reset_pos: got %b want %b", pos_leds, LED_C); end
    n_cmp++; if (score_left !== 2'd0) begin n_err++; $display("FAIL reset_score_l: got %0d want 0", score_left); end
    n_cmp++; if (score_right !== 2'd0) begin n_err++; $display("FAIL reset_score_r: got %0d want 0", score_right); end
    n_cmp++; if (hex_left !== HEX0) begin n_err++; $display("FAIL reset_hex_l: got %b want %b", hex_left, HEX0); end
    n_cmp++; if (hex_right !== HEX0) begin n_err++; $display("FAIL reset_hex_r: got %b want %b", hex_right, HEX0); end
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    n_cmp++; if (winner !== 1'b0) begin n_err++; $display("FAIL reset_winner: got %b want 0", winner); end
    n_cmp++; if (dbg_state !== S_PLAY) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_PLAY); end
  endtask

  task automatic test_left_latency();
    btn_left = 1'b1;
    tick(1);
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL lat_edge_n: got %b want %b", pos_leds, LED_C); end
    btn_left = 1'b0;
    tick(1);
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL lat_edge_n1: got %b want %b", pos_leds, LED_C); end
    tick(1);
    n_cmp++; if (pos_leds !== 9'b000100000) begin n_err++; $display("FAIL lat_edge_n2: got %b want %b", pos_leds, 9'b000100000); end
    // A long hold must count as a single press.
    btn_left = 1'b1;
    tick(20);
    btn_left = 1'b0;
    tick(3);
    n_cmp++; if (pos_leds !== 9'b001000000) begin n_err++; $display("FAIL hold_one_move: got %b want %b", pos_leds, 9'b001000000); end
  endtask

  task automatic test_btn_through_reset();
    btn_left = 1'b1;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(6);
    n_cmp++; if (pos_leds !== 9'b000100000) begin n_err++; $display("FAIL held_through_reset: got %b want %b", pos_leds, 9'b000100000); end
    tick(10);
    n_cmp++; if (pos_leds !== 9'b000100000) begin n_err++; $display("FAIL held_through_reset_late: got %b want %b", pos_leds, 9'b000100000); end
    btn_left = 1'b0;
    tick(3);
  endtask

  task automatic test_right_point();
    logic [8:0] exp;
    do_reset();
    btn_left = 1'b1;
    btn_right = 1'b1;
    tick(1);
    btn_left = 1'b0;
    btn_right = 1'b0;
    tick(3);
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL both_no_move: got %b want %b", pos_leds, LED_C); end
    exp = LED_C;
    for (int i = 0; i < 4; i++) begin
      press_right();
      exp = exp >> 1;
      n_cmp++; if (pos_leds !== exp) begin n_err++; $display("FAIL right_step%0d: got %b want %b", i, pos_leds, exp); end
    end
    press_right();
    n_cmp++; if (score_right !== 2'd1) begin n_err++; $display("FAIL right_point_score: got %0d want 1", score_right); end
    n_cmp++; if (hex_right !== HEX1) begin n_err++; $display("FAIL right_point_hex: got %b want %b", hex_right, HEX1); end
    n_cmp++; if (score_left !== 2'd0) begin n_err++; $display("FAIL right_point_score_l: got %0d want 0", score_left); end
    n_cmp++; if (pos_leds !== LED_ALL) begin n_err++; $display("FAIL right_point_leds: got %b want %b", pos_leds, LED_ALL); end
    n_cmp++; if (dbg_state !== S_HOLD) begin n_err++; $display("FAIL right_point_state: got %0d want %0d", dbg_state, S_HOLD); end
    for (int i = 1; i < 4; i++) begin
      tick(1);
      n_cmp++; if (pos_leds !== LED_ALL) begin n_err++; $display("FAIL hold_cycle%0d: got %b want %b", i, pos_leds, LED_ALL); end
    end
    tick(1);
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL hold_end_pos: got %b want %b", pos_leds, LED_C); end
    n_cmp++; if (dbg_state !== S_PLAY) begin n_err++; $display("FAIL hold_end_state: got %0d want %0d", dbg_state, S_PLAY); end
  endtask

  task automatic test_left_wins();
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      repeat (5) press_left();
      n_cmp++; if (score_left !== 2'(p)) begin n_err++; $display("FAIL left_point%0d: got %0d want %0d", p, score_left, p); end
      if (p < 3) begin
        n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL early_over%0d: got %b want 0", p, game_over); end
        tick(4);
      end
    end
    n_cmp++; if (game_over !== 1'b1) begin n_err++; $display("FAIL win_game_over: got %b want 1", game_over); end
    n_cmp++; if (winner !== 1'b1) begin n_err++; $display("FAIL win_winner: got %b want 1", winner); end
    n_cmp++; if (hex_left !== HEX3) begin n_err++; $display("FAIL win_hex_l: got %b want %b", hex_left, HEX3); end
    n_cmp++; if (pos_leds !== LED_ALL) begin n_err++; $display("FAIL win_leds: got %b want %b", pos_leds, LED_ALL); end
    n_cmp++; if (dbg_state !== S_OVER) begin n_err++; $display("FAIL win_state: got %0d want %0d", dbg_state, S_OVER); end
    press_left();
    press_left();
    press_right();
    press_right();
    n_cmp++; if (score_left !== 2'd3) begin n_err++; $display("FAIL frozen_score_l: got %0d want 3", score_left); end
    n_cmp++; if (score_right !== 2'd0) begin n_err++; $display("FAIL frozen_score_r: got %0d want 0", score_right); end
    n_cmp++; if (game_over !== 1'b1 || winner !== 1'b1) begin n_err++; $display("FAIL frozen_flags: got %b%b want 11", game_over, winner); end
    n_cmp++; if (pos_leds !== LED_ALL) begin n_err++; $display("FAIL frozen_leds: got %b want %b", pos_leds, LED_ALL); end
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL over_reset_pos: got %b want %b", pos_leds, LED_C); end
    n_cmp++; if (score_left !== 2'd0) begin n_err++; $display("FAIL over_reset_score_l: got %0d want 0", score_left); end
    n_cmp++; if (hex_left !== HEX0) begin n_err++; $display("FAIL over_reset_hex_l: got %b want %b", hex_left, HEX0); end
    n_cmp++; if (game_over !== 1'b0 || winner !== 1'b0) begin n_err++; $display("FAIL over_reset_flags: got %b%b want 00", game_over, winner); end
    n_cmp++; if (dbg_state !== S_PLAY) begin n_err++; $display("FAIL over_reset_state: got %0d want %0d", dbg_state, S_PLAY); end
  endtask

  task automatic test_cpu_never();
    do_reset();
    cpu_en = 1'b1;
    cpu_thresh = 10'd0;
    for (int i = 0; i < 40; i++) begin
      btn_right = ~btn_right;
      tick(1);
    end
    btn_right = 1'b0;
    tick(3);
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL cpu_never_pos: got %b want %b", pos_leds, LED_C); end
    press_left();
    n_cmp++; if (pos_leds !== 9'b000100000) begin n_err++; $display("FAIL cpu_left_still: got %b want %b", pos_leds, 9'b000100000); end
    cpu_en = 1'b0;
  endtask

  // Seed 3FF is not below 3FF, so the first CPU press is decided one edge late:
  // moves land at edges 3..6 after release, point at 7, 16 and 25.
  task automatic test_cpu_full();
    reset = 1'b0;
    cpu_en = 1'b1;
    cpu_thresh = 10'h3FF;
    tick(2);
    reset = 1'b1;
    tick(1);
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL cpu_edge1: got %b want %b", pos_leds, LED_C); end
    tick(1);
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL cpu_edge2: got %b want %b", pos_leds, LED_C); end
    tick(1);
    n_cmp++; if (pos_leds !== 9'b000001000) begin n_err++; $display("FAIL cpu_edge3: got %b want %b", pos_leds, 9'b000001000); end
    tick(3);
    n_cmp++; if (pos_leds !== 9'b000000001) begin n_err++; $display("FAIL cpu_edge6: got %b want %b", pos_leds, 9'b000000001); end
    tick(1);
    n_cmp++; if (score_right !== 2'd1 || pos_leds !== LED_ALL) begin n_err++; $display("FAIL cpu_point1: got %0d/%b want 1/%b", score_right, pos_leds, LED_ALL); end
    tick(4);
    n_cmp++; if (pos_leds !== LED_C || dbg_state !== S_PLAY) begin n_err++; $display("FAIL cpu_recentre: got %b/%0d want %b/%0d", pos_leds, dbg_state, LED_C, S_PLAY); end
    tick(5);
    n_cmp++; if (score_right !== 2'd2) begin n_err++; $display("FAIL cpu_point2: got %0d want 2", score_right); end
    tick(9);
    n_cmp++; if (game_over !== 1'b1) begin n_err++; $display("FAIL cpu_game_over: got %b want 1", game_over); end
    n_cmp++; if (winner !== 1'b0) begin n_err++; $display("FAIL cpu_winner: got %b want 0", winner); end
    n_cmp++; if (score_right !== 2'd3 || score_left !== 2'd0) begin n_err++; $display("FAIL cpu_final_scores: got %0d-%0d want 0-3", score_left, score_right); end
    n_cmp++; if (hex_right !== HEX3) begin n_err++; $display("FAIL cpu_hex_r: got %b want %b", hex_right, HEX3); end
    n_cmp++; if (dbg_state !== S_OVER) begin n_err++; $display("FAIL cpu_state: got %0d want %0d", dbg_state, S_OVER); end
    cpu_en = 1'b0;
    cpu_thresh = 10'd0;
  endtask

  task automatic test_reset_in_hold();
    cpu_en = 1'b0;
    do_reset();
    repeat (5) press_right();
    tick(2);
    n_cmp++; if (dbg_state !== S_HOLD) begin n_err++; $display("FAIL hold_before_reset: got %0d want %0d", dbg_state, S_HOLD); end
    reset = 1'b0;
    tick(1);
    n_cmp++; if (dbg_state !== S_PLAY) begin n_err++; $display("FAIL hold_reset_state: got %0d want %0d", dbg_state, S_PLAY); end
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL hold_reset_pos: got %b want %b", pos_leds, LED_C); end
    n_cmp++; if (score_right !== 2'd0 || hex_right !== HEX0) begin n_err++; $display("FAIL hold_reset_score: got %0d/%b want 0/%b", score_right, hex_right, HEX0); end
    // LFSR reseed is visible through the CPU press timing after release.
    cpu_en = 1'b1;
    cpu_thresh = 10'h3FF;
    tick(1);
    reset = 1'b1;
    tick(2);
    n_cmp++; if (pos_leds !== LED_C) begin n_err++; $display("FAIL hold_reset_lfsr_e2: got %b want %b", pos_leds, LED_C); end
    tick(1);
    n_cmp++; if (pos_leds !== 9'b000001000) begin n_err++; $display("FAIL hold_reset_lfsr_e3: got %b want %b", pos_leds, 9'b000001000); end
    cpu_en = 1'b0;
    cpu_thresh = 10'd0;
  endtask

  initial begin
    test_reset();
    test_left_latency();
    test_btn_through_reset();
    test_right_point();
    test_left_wins();
    test_cpu_never();
    test_cpu_full();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
